if_fetch_unit: RTL

- Instruction-fetch stage of the 16-bit pipelined CPU. It is the writer side of the IF/ID pipeline register.
- Owns the PC and issues word reads to instruction memory over a variable-latency readM/inputReady handshake.
- Buffers each returned instruction and presents it as IF_PC4/IF_instruction/IF_flush until IF/ID accepts it (IFID_WriteEn).
- Handles redirects (taken branch/jump) from later stages and a halt request.

---
 rtl/if_fetch_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word reads to instruction
// memory over a readM/inputReady handshake, and buffers each returned
// instruction until the IF/ID register accepts it.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | out of reset, no request outstanding
// S_REQ  | read request for pc outstanding
// S_HOLD | instruction buffered and presented, waiting for IF/ID
// S_DROP | abandoned request still in flight, its data is discarded
// S_HALT | halted, no fetches issued
module if_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IFID_WriteEn,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        i_readM,
  output logic [15:0] i_address,
  input  logic [15:0] i_data,
  input  logic        i_inputReady,
  output logic [15:0] IF_PC4,
  output logic [15:0] IF_instruction,
  output logic        IF_flush,
  output logic [15:0] pc,
  output logic [15:0] fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_HOLD = 3'd2,
    S_DROP = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] buf_instr_q, buf_instr_d;
  logic [15:0] buf_pc4_q, buf_pc4_d;
  logic        buf_valid_q, buf_valid_d;
  logic [15:0] drop_addr_q, drop_addr_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      buf_instr_q   <= 16'h0000;
      buf_pc4_q     <= 16'h0000;
      buf_valid_q   <= 1'b0;
      drop_addr_q   <= 16'h0000;
      fetch_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      buf_instr_q   <= buf_instr_d;
      buf_pc4_q     <= buf_pc4_d;
      buf_valid_q   <= buf_valid_d;
      drop_addr_q   <= drop_addr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Next-state and datapath updates; redirect overrides everything but reset.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_instr_d   = buf_instr_q;
    buf_pc4_d     = buf_pc4_q;
    buf_valid_d   = buf_valid_q;
    drop_addr_d   = drop_addr_q;
    fetch_count_d = fetch_count_q;

    if (redirect) begin
      pc_d = redirect_pc;
    end

    unique case (state_q)
      S_IDLE: begin
        if (redirect)  state_d = S_REQ;
        else if (halt) state_d = S_HALT;
        else           state_d = S_REQ;
      end

      S_REQ: begin
        if (redirect) begin
          // A response arriving with the redirect is simply dropped; without
          // one, the old request must be held until memory answers it.
          if (!i_inputReady) begin
            drop_addr_d = pc_q;
            state_d     = S_DROP;
          end
        end else if (i_inputReady) begin
          buf_instr_d = i_data;
          buf_pc4_d   = pc_q + 16'd1;
          buf_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          // IF_flush is already high this cycle, so IF/ID sees a bubble.
          buf_valid_d = 1'b0;
          state_d     = S_REQ;
        end else if (IFID_WriteEn) begin
          pc_d          = buf_pc4_q;
          buf_valid_d   = 1'b0;
          fetch_count_d = fetch_count_q + 16'd1;
          state_d       = halt ? S_HALT : S_REQ;
        end
      end

      S_DROP: begin
        if (i_inputReady) state_d = S_REQ;
      end

      S_HALT: begin
        if (redirect || !halt) state_d = S_REQ;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Memory request and IF/ID presentation outputs.
  always_comb begin
    i_readM        = (state_q == S_REQ) || (state_q == S_DROP);
    i_address      = (state_q == S_DROP) ? drop_addr_q : pc_q;
    IF_flush       = ~buf_valid_q | redirect;
    IF_instruction = IF_flush ? 16'h0000 : buf_instr_q;
    IF_PC4         = IF_flush ? 16'h0000 : buf_pc4_q;
    pc             = pc_q;
    fetch_count    = fetch_count_q;
  end

endmodule
